// File: rtl/ascon_host_pkg.sv
// Shared definitions for the Ascon serial host: FSM state encoding,
// share-randomness LFSR constants and the operation mode codes.
package ascon_host_pkg;

    // Transaction phases of the host sequencer
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_READ  = 3'd5,
        ST_DONE  = 3'd6
    } host_state_e;

    // Operation selected by mode_i
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // 32-bit Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Random bits consumed per cycle: 4 serial lanes x 2 share bits + 7 bits of r_so
    localparam int RAND_W = 15;

    // One LFSR advance
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/ascon_host_lfsr.sv
// Free-running share-randomness source for the serial host. Only built when
// RAND_SHARES_EN is defined. Every state bit is folded into the output so the
// whole register contributes; requires 11 <= OUT_W <= 32.
module ascon_host_lfsr
    import ascon_host_pkg::*;
#(
    parameter int OUT_W = RAND_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rand_o
);

    logic [31:0] r_state;

    // Advance the generator once per clock, restart from the fixed seed on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LFSR_SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    // Fold state bits gi, gi+OUT_W, gi+2*OUT_W onto output bit gi
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_fold
        if (gi + 2 * OUT_W < 32) begin : g_three
            assign rand_o[gi] = r_state[gi] ^ r_state[gi + OUT_W] ^ r_state[gi + 2 * OUT_W];
        end else if (gi + OUT_W < 32) begin : g_two
            assign rand_o[gi] = r_state[gi] ^ r_state[gi + OUT_W];
        end else begin : g_one
            assign rand_o[gi] = r_state[gi];
        end
    end

endmodule

// File: rtl/ascon_serial_host.sv
// Host end of the Ascon core's bit-serial port: shifts key/nonce/AD/PT into
// the core MSB-first, raises the encrypt/decrypt start, waits for ready
// (with timeout), then deserializes the CT/tag streams after an encryption.
// Optional feature macro: RAND_SHARES_EN (LFSR-driven share bits and r_so);
// when undefined all random bits are tied to 0.
module ascon_serial_host
    import ascon_host_pkg::*;
#(
    parameter int K       = 128,
    parameter int L       = 40,
    parameter int Y       = 40,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [K-1:0]     key_i,
    input  logic [K-1:0]     nonce_i,
    input  logic [L-1:0]     ad_i,
    input  logic [Y-1:0]     pt_i,
    output logic [2:0]       key_so,
    output logic [2:0]       nonce_so,
    output logic [2:0]       ad_so,
    output logic [2:0]       pt_so,
    output logic [6:0]       r_so,
    output logic             enc_start_o,
    output logic             dec_start_o,
    input  logic             ct_si,
    input  logic             tag_si,
    input  logic             enc_ready_i,
    input  logic             dec_ready_i,
    output logic [Y-1:0]     ct_o,
    output logic [K-1:0]     tag_o,
    output logic [CNT_W-1:0] latency_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(K) + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] IDX_GAP_LAST = IDX_W'(GAP - 1);
    localparam logic [IDX_W-1:0] IDX_Y        = IDX_W'(Y);
    localparam logic [TW-1:0]    WAIT_LAST    = TW'(TIMEOUT - 1);

    host_state_e      r_state;
    host_state_e      w_state_next;
    logic [K-1:0]     r_key;
    logic [K-1:0]     r_nonce;
    logic [L-1:0]     r_ad;
    logic [Y-1:0]     r_pt;
    logic             r_mode;
    logic [IDX_W-1:0] r_idx;
    logic [TW-1:0]    r_wait;
    logic [CNT_W-1:0] r_lat;
    logic             r_err;
    logic [Y-1:0]     r_ct;
    logic [K-1:0]     r_tag;
    logic [RAND_W-1:0] w_rand;
    logic             w_ready;
    logic             w_timeout;
    logic             w_load;
    logic             w_start_phase;

`ifdef RAND_SHARES_EN
    ascon_host_lfsr #(
        .OUT_W (RAND_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .rand_o (w_rand)
    );
`else
    assign w_rand = '0;
`endif

    // Only the ready line matching the running operation counts
    assign w_ready       = (r_mode == MODE_ENC) ? enc_ready_i : dec_ready_i;
    assign w_timeout     = (r_wait == WAIT_LAST);
    assign w_load        = (r_state == ST_LOAD);
    assign w_start_phase = (r_state == ST_START) || (r_state == ST_WAIT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: ready beats timeout when both land in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_next = ST_LOAD;
            ST_LOAD:  if (r_idx == IDX_LAST) w_state_next = ST_START;
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_ready) begin
                    if (r_mode == MODE_ENC) begin
                        w_state_next = (GAP == 0) ? ST_READ : ST_GAP;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_GAP:   if (r_idx == IDX_GAP_LAST) w_state_next = ST_READ;
            ST_READ:  if (r_idx == IDX_LAST) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand shifters, phase index, wait/latency counters, capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key   <= '0;
            r_nonce <= '0;
            r_ad    <= '0;
            r_pt    <= '0;
            r_mode  <= MODE_ENC;
            r_idx   <= '0;
            r_wait  <= '0;
            r_lat   <= '0;
            r_err   <= 1'b0;
            r_ct    <= '0;
            r_tag   <= '0;
        end else begin
            // Phase index restarts at every state change
            if (w_state_next != r_state) begin
                r_idx <= '0;
            end else if (w_load || (r_state == ST_GAP) || (r_state == ST_READ)) begin
                r_idx <= r_idx + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_key   <= key_i;
                        r_nonce <= nonce_i;
                        r_ad    <= ad_i;
                        r_pt    <= pt_i;
                        r_mode  <= mode_i;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // MSB leaves first; AD/PT run out to zeros once exhausted
                    r_key   <= r_key << 1;
                    r_nonce <= r_nonce << 1;
                    r_ad    <= r_ad << 1;
                    r_pt    <= r_pt << 1;
                    if (w_state_next == ST_START) begin
                        r_lat <= '0;
                    end
                end
                ST_START: begin
                    r_wait <= '0;
                    if (r_lat != '1) r_lat <= r_lat + 1'b1;
                end
                ST_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (r_lat != '1) r_lat <= r_lat + 1'b1;
                    if (!w_ready && w_timeout) r_err <= 1'b1;
                end
                ST_READ: begin
                    // Sample i lands in bit i after the full stream has shifted in
                    r_tag <= {tag_si, r_tag[K-1:1]};
                    if (r_idx < IDX_Y) r_ct <= {ct_si, r_ct[Y-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign key_so      = {w_rand[1:0],  w_load & r_key[K-1]};
    assign nonce_so    = {w_rand[3:2],  w_load & r_nonce[K-1]};
    assign ad_so       = {w_rand[5:4],  w_load & r_ad[L-1]};
    assign pt_so       = {w_rand[7:6],  w_load & r_pt[Y-1]};
    assign r_so        = w_rand[14:8];
    assign enc_start_o = w_start_phase && (r_mode == MODE_ENC);
    assign dec_start_o = w_start_phase && (r_mode == MODE_DEC);
    assign ct_o        = r_ct;
    assign tag_o       = r_tag;
    assign latency_o   = r_lat;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = r_err;

endmodule
